// File: rtl/pmem_arbiter.sv
// Physical-memory arbiter: shares one line-wide memory port between the
// I-cache (read only) and D-cache (read/writeback) using a 3-state FSM.
// Ports: clk, rst_n (async, active-low); i_pmem_* from/to the I-cache;
// d_pmem_* from/to the D-cache; pmem_* to/from physical memory.
// Option: define ARB_RR_EN for round-robin tie-breaking; default D wins ties.
module pmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic              i_pmem_read,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t state;
    logic   i_req;
    logic   d_req;
    logic   grant_i;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_RR_EN
    // last_d set means D was the most recent owner, so I wins the next tie
    logic last_d;
    assign grant_i = i_req & (~d_req | last_d);
`else
    assign grant_i = i_req & ~d_req;
`endif

    // Responses are qualified by ownership so a stray memory strobe in
    // IDLE never reaches either cache.
    assign i_pmem_resp  = pmem_resp & (state == BUSY_I);
    assign d_pmem_resp  = pmem_resp & (state == BUSY_D);
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
`ifdef ARB_RR_EN
            last_d       <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state        <= BUSY_I;
                        pmem_address <= i_pmem_address;
                        pmem_read    <= 1'b1;
                        pmem_write   <= 1'b0;
`ifdef ARB_RR_EN
                        last_d       <= 1'b0;
`endif
                    end else if (d_req) begin
                        // read+write together is treated as a writeback
                        state        <= BUSY_D;
                        pmem_address <= d_pmem_address;
                        pmem_wdata   <= d_pmem_wdata;
                        pmem_read    <= d_pmem_read & ~d_pmem_write;
                        pmem_write   <= d_pmem_write;
`ifdef ARB_RR_EN
                        last_d       <= 1'b1;
`endif
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (pmem_resp) begin
                        state      <= IDLE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: memory responder with scoreboard,
// scenario tasks for reads, writebacks, ties, holds and reset.
module tb_pmem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] i_pmem_address;
    logic          i_pmem_read;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic [AW-1:0] d_pmem_address;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_read;
    logic          pmem_write;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp  = 1'b0;

    typedef struct {
        bit            own_d;
        logic [AW-1:0] addr;
        bit            wr;
        logic [LW-1:0] wdata;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   lat    = 3;
    int   cnt    = 0;
    int   i_cnt  = 0;
    int   d_cnt  = 0;
    bit   mem_en = 1'b0;
    bit   last_d = 1'b1;

    pmem_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pmem_address(i_pmem_address),
        .i_pmem_read   (i_pmem_read),
        .i_pmem_rdata  (i_pmem_rdata),
        .i_pmem_resp   (i_pmem_resp),
        .d_pmem_address(d_pmem_address),
        .d_pmem_read   (d_pmem_read),
        .d_pmem_write  (d_pmem_write),
        .d_pmem_wdata  (d_pmem_wdata),
        .d_pmem_rdata  (d_pmem_rdata),
        .d_pmem_resp   (d_pmem_resp),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] line_of(logic [AW-1:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    // Memory model: checks the latched request every busy cycle against the
    // scoreboard head, then strobes pmem_resp after 'lat' cycles.
    always @(negedge clk) begin
        if (!mem_en) begin
            cnt = 0;
        end else if (pmem_resp) begin
            pmem_resp = 1'b0;
            cnt = 0;
        end else if (pmem_read || pmem_write) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_op addr=%h rd=%b wr=%b",
                         pmem_address, pmem_read, pmem_write);
            end else begin
                cur = sb[0];
                if (pmem_address !== cur.addr || pmem_write !== cur.wr ||
                    pmem_read !== !cur.wr ||
                    (cur.wr && pmem_wdata !== cur.wdata)) begin
                    errors++;
                    $display("FAIL hold addr=%h rd=%b wr=%b want addr=%h wr=%b",
                             pmem_address, pmem_read, pmem_write,
                             cur.addr, cur.wr);
                end
                cnt++;
                if (cnt >= lat) begin
                    pmem_rdata = line_of(pmem_address);
                    pmem_resp  = 1'b1;
                    #1;
                    checks++;
                    if (i_pmem_resp !== !cur.own_d ||
                        d_pmem_resp !== cur.own_d ||
                        i_pmem_rdata !== pmem_rdata ||
                        d_pmem_rdata !== pmem_rdata) begin
                        errors++;
                        $display("FAIL resp i=%b d=%b want_d_owner=%b",
                                 i_pmem_resp, d_pmem_resp, cur.own_d);
                    end
                    if (cur.own_d) d_cnt++;
                    else i_cnt++;
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic push(bit own_d, logic [AW-1:0] a, bit wr,
                        logic [LW-1:0] wd);
        exp_t e;
        e.own_d = own_d;
        e.addr  = a;
        e.wr    = wr;
        e.wdata = wd;
        sb.push_back(e);
        last_d = own_d;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_pmem_address = '0;
        i_pmem_read = 1'b0;
        d_pmem_address = '0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_wdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_rw rd=%b wr=%b want 0 0", pmem_read, pmem_write);
        end
        checks++;
        if (pmem_address !== '0 || pmem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_regs addr=%h want 0", pmem_address);
        end
        checks++;
        if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp i=%b d=%b want 0 0", i_pmem_resp, d_pmem_resp);
        end
        rst_n = 1'b1;
        mem_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_i_read();
        int i0 = i_cnt;
        int d0 = d_cnt;
        bit ok;
        lat = 3;
        push(1'b0, 32'h0000_1000, 1'b0, '0);
        i_pmem_address = 32'h0000_1000;
        i_pmem_read = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 ||
            pmem_address !== 32'h0000_1000) begin
            errors++;
            $display("FAIL i_grant rd=%b wr=%b addr=%h want 1 0 00001000",
                     pmem_read, pmem_write, pmem_address);
        end
        @(negedge clk);
        i_pmem_read = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || i_cnt - i0 != 1 || d_cnt != d0) begin
            errors++;
            $display("FAIL i_read_count i=%0d d=%0d want 1 0", i_cnt - i0, d_cnt - d0);
        end
    endtask

    task automatic test_d_write();
        int i0 = i_cnt;
        int d0 = d_cnt;
        bit ok;
        logic [LW-1:0] wd = {32{8'hA5}};
        lat = 4;
        push(1'b1, 32'h0000_2020, 1'b1, wd);
        d_pmem_address = 32'h0000_2020;
        d_pmem_wdata = wd;
        d_pmem_write = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_wdata !== wd) begin
            errors++;
            $display("FAIL d_grant rd=%b wr=%b want 0 1", pmem_read, pmem_write);
        end
        @(negedge clk);
        d_pmem_write = 1'b0;
        d_pmem_wdata = '0;
        wait_done(ok);
        checks++;
        if (!ok || d_cnt - d0 != 1 || i_cnt != i0) begin
            errors++;
            $display("FAIL d_write_count d=%0d i=%0d want 1 0", d_cnt - d0, i_cnt - i0);
        end
    endtask

    task automatic test_rw_both();
        bit ok;
        logic [LW-1:0] wd = {8{$urandom()}};
        lat = 2;
        push(1'b1, 32'h0000_3040, 1'b1, wd);
        d_pmem_address = 32'h0000_3040;
        d_pmem_wdata = wd;
        d_pmem_read = 1'b1;
        d_pmem_write = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL rw_both rd=%b wr=%b want 0 1", pmem_read, pmem_write);
        end
        @(negedge clk);
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rw_both_done timeout");
        end
    endtask

    task automatic test_addr_change();
        bit ok;
        lat = 5;
        push(1'b0, 32'h0000_1000, 1'b0, '0);
        i_pmem_address = 32'h0000_1000;
        i_pmem_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_pmem_address = 32'hFFFF_FFE0;
        repeat (2) @(negedge clk);
        checks++;
        if (pmem_address !== 32'h0000_1000) begin
            errors++;
            $display("FAIL addr_hold got=%h want 00001000", pmem_address);
        end
        i_pmem_read = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL addr_change_done timeout");
        end
    endtask

    task automatic test_tie();
        for (int r = 0; r < 2; r++) begin
            int i0 = i_cnt;
            int d0 = d_cnt;
            bit win_d;
            bit ok;
            bit seen = 1'b0;
            logic [AW-1:0] ia = 32'h0000_5000 + 32'(r * 64);
            logic [AW-1:0] da = 32'h0000_4000 + 32'(r * 64);
            logic [AW-1:0] la;
`ifdef ARB_RR_EN
            win_d = !last_d;
`else
            win_d = 1'b1;
`endif
            la = win_d ? ia : da;
            if (win_d) begin
                push(1'b1, da, 1'b0, '0);
                push(1'b0, ia, 1'b0, '0);
            end else begin
                push(1'b0, ia, 1'b0, '0);
                push(1'b1, da, 1'b0, '0);
            end
            lat = 2 + r;
            i_pmem_address = ia;
            d_pmem_address = da;
            i_pmem_read = 1'b1;
            d_pmem_read = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (pmem_address !== (win_d ? da : ia)) begin
                errors++;
                $display("FAIL tie_winner round=%0d addr=%h want_d=%b",
                         r, pmem_address, win_d);
            end
            @(negedge clk);
            if (win_d) d_pmem_read = 1'b0;
            else i_pmem_read = 1'b0;
            for (int k = 0; k < 50; k++) begin
                if (pmem_address === la && (pmem_read || pmem_write)) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            i_pmem_read = 1'b0;
            d_pmem_read = 1'b0;
            wait_done(ok);
            checks++;
            if (!seen || !ok || i_cnt - i0 != 1 || d_cnt - d0 != 1) begin
                errors++;
                $display("FAIL tie_pair round=%0d seen=%b i=%0d d=%0d want 1 1",
                         r, seen, i_cnt - i0, d_cnt - d0);
            end
        end
    endtask

    task automatic test_reset_busy_d();
        lat = 20;
        push(1'b1, 32'h0000_6000, 1'b1, {8{32'hDEAD_BEEF}});
        d_pmem_address = 32'h0000_6000;
        d_pmem_wdata = {8{32'hDEAD_BEEF}};
        d_pmem_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_pmem_write = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        mem_en = 1'b0;
        #1;
        checks++;
        if (pmem_write !== 1'b0 || pmem_address !== '0 || pmem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_busy wr=%b addr=%h want 0 0", pmem_write, pmem_address);
        end
        sb.delete();
        last_d = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        checks++;
        if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
            errors++;
            $display("FAIL stray_resp i=%b d=%b want 0 0", i_pmem_resp, d_pmem_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle rd=%b wr=%b want 0 0", pmem_read, pmem_write);
        end
        lat = 3;
        mem_en = 1'b1;
    endtask

    task automatic test_random_seq();
        for (int n = 0; n < 8; n++) begin
            bit ok;
            int kind = $urandom_range(2, 0);
            logic [AW-1:0] a = {$urandom_range(32'hFFFF, 0), 5'b0} + 32'h0001_0000;
            logic [LW-1:0] wd = {8{$urandom()}};
            lat = $urandom_range(4, 1);
            if (kind == 0) begin
                push(1'b0, a, 1'b0, '0);
                i_pmem_address = a;
                i_pmem_read = 1'b1;
            end else begin
                push(1'b1, a, kind == 2, wd);
                d_pmem_address = a;
                d_pmem_wdata = wd;
                d_pmem_read = (kind == 1);
                d_pmem_write = (kind == 2);
            end
            @(posedge clk);
            @(negedge clk);
            i_pmem_read = 1'b0;
            d_pmem_read = 1'b0;
            d_pmem_write = 1'b0;
            wait_done(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL random_seq n=%0d timeout", n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_rw_both();
        test_addr_change();
        test_tie();
        test_reset_busy_d();
        test_random_seq();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_sb got=%0d want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
